// File: rtl/gpr_access_seq.sv
// ---------------------------------------------------------------------------
// gpr_access_seq
//
// Bus initiator for a single-port general-purpose register file
// (2**ADDR_WIDTH x DATA_WIDTH, register 0 reads as zero). One request per
// valid/ready transaction is serialised into write, read-A and read-B bus
// cycles on the register-file Read/Write/Address bus. The fetched operands
// are returned on a valid/ready response channel.
//
// Build option:
//   GPRSEQ_BYPASS_EN  when defined, a read whose address matches a non-zero
//                     write address of the same request takes its operand
//                     from the latched write data and skips the bus read.
//
// Ports:
//   i_clock, i_reset        clock, synchronous active-high reset
//   i_req_valid/o_req_ready request handshake
//   i_req_rd_a/_rd_b/_wr    requested operations
//   i_addr_a/_b/_w          read-A, read-B and write register numbers
//   i_wr_data               write data
//   o_rsp_valid/i_rsp_ready response handshake
//   o_op_a, o_op_b          returned operands
//   o_gpr_address           register-file address
//   o_gpr_read/_write       register-file strobes
//   o_gpr_wdata             register-file write data
//   i_gpr_rdata             register-file read data
// ---------------------------------------------------------------------------
// state  | meaning
// IDLE   | ready for a request, bus idle
// WRITE  | write strobe to AddrW with WrData
// READ_A | read strobe to AddrA, OpA captured at end of cycle
// READ_B | read strobe to AddrB, OpB captured at end of cycle
// RESP   | operands presented, waiting for RspReady
// ---------------------------------------------------------------------------
module gpr_access_seq #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic                  i_req_valid,
  output logic                  o_req_ready,
  input  logic                  i_req_rd_a,
  input  logic                  i_req_rd_b,
  input  logic                  i_req_wr,
  input  logic [ADDR_WIDTH-1:0] i_addr_a,
  input  logic [ADDR_WIDTH-1:0] i_addr_b,
  input  logic [ADDR_WIDTH-1:0] i_addr_w,
  input  logic [DATA_WIDTH-1:0] i_wr_data,
  output logic                  o_rsp_valid,
  input  logic                  i_rsp_ready,
  output logic [DATA_WIDTH-1:0] o_op_a,
  output logic [DATA_WIDTH-1:0] o_op_b,
  output logic [ADDR_WIDTH-1:0] o_gpr_address,
  output logic                  o_gpr_read,
  output logic                  o_gpr_write,
  output logic [DATA_WIDTH-1:0] o_gpr_wdata,
  input  logic [DATA_WIDTH-1:0] i_gpr_rdata
);

`ifdef GPRSEQ_BYPASS_EN
  localparam logic BYPASS_EN = 1'b1;
`else
  localparam logic BYPASS_EN = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_READ_A,
    S_READ_B,
    S_RESP
  } state_t;

  state_t                r_state;
  state_t                w_next_state;

  logic                  r_rd_a;
  logic                  r_rd_b;
  logic                  r_wr;
  logic [ADDR_WIDTH-1:0] r_addr_a;
  logic [ADDR_WIDTH-1:0] r_addr_b;
  logic [ADDR_WIDTH-1:0] r_addr_w;
  logic [DATA_WIDTH-1:0] r_wr_data;
  logic [DATA_WIDTH-1:0] r_op_a;
  logic [DATA_WIDTH-1:0] r_op_b;

  logic                  w_accept;

  // Phase requirements of the incoming request (used only on accept).
  logic                  w_in_need_w;
  logic                  w_in_hit_a;
  logic                  w_in_hit_b;
  logic                  w_in_need_a;
  logic                  w_in_need_b;

  // Phase requirements of the latched request.
  logic                  w_need_a;
  logic                  w_need_b;

  // First phase still to run, in write-then-A-then-B order. RESP only
  // follows if an operand was asked for; a write-only request goes idle.
  function automatic state_t first_phase(input logic need_w, input logic need_a,
                                         input logic need_b, input logic any_rd);
    if (need_w)      return S_WRITE;
    else if (need_a) return S_READ_A;
    else if (need_b) return S_READ_B;
    else if (any_rd) return S_RESP;
    else             return S_IDLE;
  endfunction

  assign w_accept    = (r_state == S_IDLE) && i_req_valid;

  // Register 0 never needs a bus cycle: writes are dropped, reads are zero.
  assign w_in_need_w = i_req_wr && (i_addr_w != '0);
  assign w_in_hit_a  = BYPASS_EN && w_in_need_w && (i_addr_a == i_addr_w);
  assign w_in_hit_b  = BYPASS_EN && w_in_need_w && (i_addr_b == i_addr_w);
  assign w_in_need_a = i_req_rd_a && (i_addr_a != '0) && !w_in_hit_a;
  assign w_in_need_b = i_req_rd_b && (i_addr_b != '0) && !w_in_hit_b;

  assign w_need_a = r_rd_a && (r_addr_a != '0) &&
                    !(BYPASS_EN && r_wr && (r_addr_w != '0) && (r_addr_a == r_addr_w));
  assign w_need_b = r_rd_b && (r_addr_b != '0) &&
                    !(BYPASS_EN && r_wr && (r_addr_w != '0) && (r_addr_b == r_addr_w));

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (i_req_valid) begin
          w_next_state = first_phase(w_in_need_w, w_in_need_a, w_in_need_b,
                                     i_req_rd_a || i_req_rd_b);
        end
      end
      S_WRITE:  w_next_state = first_phase(1'b0, w_need_a, w_need_b, r_rd_a || r_rd_b);
      S_READ_A: w_next_state = first_phase(1'b0, 1'b0, w_need_b, 1'b1);
      S_READ_B: w_next_state = S_RESP;
      S_RESP: begin
        if (i_rsp_ready) begin
          w_next_state = S_IDLE;
        end
      end
      default:  w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state   <= S_IDLE;
      r_rd_a    <= 1'b0;
      r_rd_b    <= 1'b0;
      r_wr      <= 1'b0;
      r_addr_a  <= '0;
      r_addr_b  <= '0;
      r_addr_w  <= '0;
      r_wr_data <= '0;
      r_op_a    <= '0;
      r_op_b    <= '0;
    end else begin
      r_state <= w_next_state;

      if (w_accept) begin
        r_rd_a    <= i_req_rd_a;
        r_rd_b    <= i_req_rd_b;
        r_wr      <= i_req_wr;
        r_addr_a  <= i_addr_a;
        r_addr_b  <= i_addr_b;
        r_addr_w  <= i_addr_w;
        r_wr_data <= i_wr_data;

        // Operands that skip their bus read are resolved at accept time.
        if (i_req_rd_a && (i_addr_a == '0)) begin
          r_op_a <= '0;
        end else if (i_req_rd_a && w_in_hit_a) begin
          r_op_a <= i_wr_data;
        end

        if (i_req_rd_b && (i_addr_b == '0)) begin
          r_op_b <= '0;
        end else if (i_req_rd_b && w_in_hit_b) begin
          r_op_b <= i_wr_data;
        end
      end

      if (r_state == S_READ_A) begin
        r_op_a <= i_gpr_rdata;
      end
      if (r_state == S_READ_B) begin
        r_op_b <= i_gpr_rdata;
      end
    end
  end

  // Moore decode from state and latched request; the bus idles at zero.
  always_comb begin
    o_req_ready   = 1'b0;
    o_rsp_valid   = 1'b0;
    o_gpr_read    = 1'b0;
    o_gpr_write   = 1'b0;
    o_gpr_address = '0;
    o_gpr_wdata   = '0;
    case (r_state)
      S_IDLE: o_req_ready = 1'b1;
      S_WRITE: begin
        o_gpr_write   = 1'b1;
        o_gpr_address = r_addr_w;
        o_gpr_wdata   = r_wr_data;
      end
      S_READ_A: begin
        o_gpr_read    = 1'b1;
        o_gpr_address = r_addr_a;
      end
      S_READ_B: begin
        o_gpr_read    = 1'b1;
        o_gpr_address = r_addr_b;
      end
      S_RESP: o_rsp_valid = 1'b1;
      default: ;
    endcase
  end

  assign o_op_a = r_op_a;
  assign o_op_b = r_op_b;

endmodule

// File: tb/tb_gpr_access_seq.sv
module tb_gpr_access_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_rd_a;
  logic        req_rd_b;
  logic        req_wr;
  logic [2:0]  addr_a;
  logic [2:0]  addr_b;
  logic [2:0]  addr_w;
  logic [15:0] wr_data;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] op_a;
  logic [15:0] op_b;
  logic [2:0]  gpr_address;
  logic        gpr_read;
  logic        gpr_write;
  logic [15:0] gpr_wdata;
  logic [15:0] gpr_rdata;

  gpr_access_seq #(.DATA_WIDTH(16), .ADDR_WIDTH(3)) dut (
    .i_clock      (clk),
    .i_reset      (rst),
    .i_req_valid  (req_valid),
    .o_req_ready  (req_ready),
    .i_req_rd_a   (req_rd_a),
    .i_req_rd_b   (req_rd_b),
    .i_req_wr     (req_wr),
    .i_addr_a     (addr_a),
    .i_addr_b     (addr_b),
    .i_addr_w     (addr_w),
    .i_wr_data    (wr_data),
    .o_rsp_valid  (rsp_valid),
    .i_rsp_ready  (rsp_ready),
    .o_op_a       (op_a),
    .o_op_b       (op_b),
    .o_gpr_address(gpr_address),
    .o_gpr_read   (gpr_read),
    .o_gpr_write  (gpr_write),
    .o_gpr_wdata  (gpr_wdata),
    .i_gpr_rdata  (gpr_rdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks   = 0;
  int failures = 0;
  logic mon_en = 1'b0;

  // Register file model: reg 0 reads zero, undriven bus shows garbage.
  logic [15:0] mem [8];
  logic        pl_en = 1'b0;
  logic [2:0]  pl_addr = 3'd0;
  logic [15:0] pl_data = 16'h0;

  always @(posedge clk) begin
    if (rst && !mon_en) begin
      for (int i = 0; i < 8; i++) mem[i] <= 16'h0;
    end else if (pl_en) begin
      mem[pl_addr] <= pl_data;
    end else if (gpr_write && gpr_address != 3'd0) begin
      mem[gpr_address] <= gpr_wdata;
    end
  end

  assign gpr_rdata = gpr_read ? ((gpr_address == 3'd0) ? 16'h0 : mem[gpr_address]) : 16'hDEAD;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    int          t;
  } rsp_t;

  typedef struct {
    logic        wr;
    logic [2:0]  addr;
    logic [15:0] data;
  } bus_t;

  rsp_t rsp_q[$];
  bus_t bus_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_bus(input logic wr, input logic [2:0] addr, input logic [15:0] data);
    bus_t e;
    e.wr = wr; e.addr = addr; e.data = data;
    bus_q.push_back(e);
  endtask

  // Issues one request; expected response (if any) is queued with the
  // cycle in which RspValid must first rise (accept edge + lat), or -1 to
  // leave latency unchecked.
  task automatic send_req(input logic rd_a, input logic rd_b, input logic wr,
                          input logic [2:0] aa, input logic [2:0] ab, input logic [2:0] aw,
                          input logic [15:0] wd, input logic exp_rsp,
                          input logic [15:0] ea, input logic [15:0] eb, input int lat,
                          output int t_acc);
    rsp_t r;
    int   n;
    req_rd_a = rd_a; req_rd_b = rd_b; req_wr = wr;
    addr_a = aa; addr_b = ab; addr_w = aw; wr_data = wd;
    req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 60) begin
      step();
      n++;
    end
    t_acc = cyc + 1;
    checks++;
    if (!req_ready) begin
      failures++;
      $display("FAIL req_accept_timeout: ready stuck low required high");
    end else if (exp_rsp) begin
      r.a = ea; r.b = eb; r.t = (lat < 0) ? -1 : t_acc + lat;
      rsp_q.push_back(r);
    end
    step();
    req_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((rsp_q.size() != 0 || bus_q.size() != 0) && n < 60) begin
      step();
      n++;
    end
    check("drain_rsp_q", 32'(rsp_q.size()), 32'd0);
    check("drain_bus_q", 32'(bus_q.size()), 32'd0);
  endtask

  // Bus monitor.
  initial begin
    bus_t e;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        check("bus_exclusive", 32'(gpr_read & gpr_write), 32'd0);
        if (!gpr_read && !gpr_write) begin
          check("bus_idle_addr", 32'(gpr_address), 32'd0);
          check("bus_idle_wdata", 32'(gpr_wdata), 32'd0);
        end else if (bus_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL bus_unexpected: got rd=%0b wr=%0b addr=%0d required no strobe",
                   gpr_read, gpr_write, gpr_address);
        end else begin
          e = bus_q.pop_front();
          check("bus_kind_write", 32'(gpr_write), 32'(e.wr));
          check("bus_addr", 32'(gpr_address), 32'(e.addr));
          if (e.wr) check("bus_wdata", 32'(gpr_wdata), 32'(e.data));
        end
      end
    end
  end

  // Response monitor / scoreboard.
  initial begin
    rsp_t        e;
    logic        seen;
    int          first;
    logic [15:0] ha;
    logic [15:0] hb;
    seen = 1'b0; first = 0; ha = 16'h0; hb = 16'h0;
    forever begin
      @(negedge clk);
      if (mon_en && rsp_valid) begin
        if (!seen) begin
          seen = 1'b1; first = cyc; ha = op_a; hb = op_b;
        end else begin
          check("rsp_stable_a", 32'(op_a), 32'(ha));
          check("rsp_stable_b", 32'(op_b), 32'(hb));
          check("req_ready_in_resp", 32'(req_ready), 32'd0);
        end
        if (rsp_ready) begin
          seen = 1'b0;
          if (rsp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL rsp_unexpected: got valid response required none");
          end else begin
            e = rsp_q.pop_front();
            check("rsp_op_a", 32'(op_a), 32'(e.a));
            check("rsp_op_b", 32'(op_b), 32'(e.b));
            if (e.t >= 0) check("rsp_latency", 32'(first), 32'(e.t));
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  int t1, t2, t3, h_edge;

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_rd_a = 1'b0; req_rd_b = 1'b0; req_wr = 1'b0;
    addr_a = 3'd0; addr_b = 3'd0; addr_w = 3'd0; wr_data = 16'h0; rsp_ready = 1'b1;
    h_edge = 0;
    step(); step();
    rst = 1'b0;
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_strobes", 32'({gpr_read, gpr_write}), 32'd0);
    check("rst_addr", 32'(gpr_address), 32'd0);
    check("rst_ops", {op_a, op_b}, 32'd0);
    mon_en = 1'b1;

    pl_en = 1'b1;
    pl_addr = 3'd3; pl_data = 16'h1234; step();
    pl_addr = 3'd5; pl_data = 16'h00FF; step();
    pl_addr = 3'd4; pl_data = 16'h1111; step();
    pl_en = 1'b0;

    // Full request: write then two reads, read-A sees the new value.
    push_bus(1'b1, 3'd3, 16'hBEEF);
    push_bus(1'b0, 3'd3, 16'h0);
    push_bus(1'b0, 3'd5, 16'h0);
`ifdef GPRSEQ_BYPASS_EN
    bus_q.delete(1);
    send_req(1, 1, 1, 3'd3, 3'd5, 3'd3, 16'hBEEF, 1, 16'hBEEF, 16'h00FF, 2, t1);
`else
    send_req(1, 1, 1, 3'd3, 3'd5, 3'd3, 16'hBEEF, 1, 16'hBEEF, 16'h00FF, 3, t1);
`endif
    drain();

    // Register 0 everywhere: no bus activity, zero operands.
    send_req(1, 1, 1, 3'd0, 3'd0, 3'd0, 16'hFFFF, 1, 16'h0000, 16'h0000, -1, t1);
    drain();

    // Read-after-write to the same register within one request.
    push_bus(1'b1, 3'd2, 16'h0042);
`ifdef GPRSEQ_BYPASS_EN
    push_bus(1'b0, 3'd4, 16'h0);
    send_req(1, 1, 1, 3'd2, 3'd4, 3'd2, 16'h0042, 1, 16'h0042, 16'h1111, 2, t1);
`else
    push_bus(1'b0, 3'd2, 16'h0);
    push_bus(1'b0, 3'd4, 16'h0);
    send_req(1, 1, 1, 3'd2, 3'd4, 3'd2, 16'h0042, 1, 16'h0042, 16'h1111, 3, t1);
`endif
    drain();

    // Request with no operations is accepted and leaves the FSM idle.
    send_req(0, 0, 0, 3'd1, 3'd1, 3'd1, 16'h5555, 0, 16'h0, 16'h0, 0, t1);
    send_req(0, 0, 0, 3'd2, 3'd2, 3'd2, 16'h6666, 0, 16'h0, 16'h0, 0, t2);
    check("noop_back_to_back", 32'(t2), 32'(t1 + 1));
    drain();

    // Response backpressure, then write-only and its readback.
    push_bus(1'b0, 3'd5, 16'h0);
    push_bus(1'b0, 3'd3, 16'h0);
    push_bus(1'b1, 3'd7, 16'hA5A5);
    push_bus(1'b0, 3'd7, 16'h0);
    rsp_ready = 1'b0;
    fork
      begin
        send_req(1, 1, 0, 3'd5, 3'd3, 3'd0, 16'h0, 1, 16'h00FF, 16'hBEEF, 2, t1);
        send_req(0, 0, 1, 3'd0, 3'd0, 3'd7, 16'hA5A5, 0, 16'h0, 16'h0, 0, t2);
        send_req(1, 0, 0, 3'd7, 3'd0, 3'd0, 16'h0, 1, 16'hA5A5, 16'hBEEF, 1, t3);
      end
      begin
        int n = 0;
        while (!rsp_valid && n < 60) begin
          step();
          n++;
        end
        check("bp_rsp_seen", 32'(rsp_valid), 32'd1);
        repeat (5) begin
          check("bp_req_ready_low", 32'(req_ready), 32'd0);
          check("bp_rsp_valid_high", 32'(rsp_valid), 32'd1);
          step();
        end
        rsp_ready = 1'b1;
        h_edge = cyc + 1;
      end
    join
    check("bp_next_accept", 32'(t2), 32'(h_edge + 1));
    check("wronly_next_accept", 32'(t3), 32'(t2 + 2));
    drain();

    // Reset in the middle of READ_A discards the request.
    push_bus(1'b0, 3'd3, 16'h0);
    send_req(1, 1, 0, 3'd3, 3'd5, 3'd0, 16'h0, 0, 16'h0, 16'h0, 0, t1);
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    check("mid_rst_req_ready", 32'(req_ready), 32'd1);
    check("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("mid_rst_strobes", 32'({gpr_read, gpr_write}), 32'd0);
    check("mid_rst_op_a", 32'(op_a), 32'd0);
    check("mid_rst_op_b", 32'(op_b), 32'd0);
    repeat (4) step();
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
